// File: rtl/braille_entry_capture_pkg.sv
// Shared cell width, default code length and entry state encoding.
package braille_pkg;
    localparam int CELL_W     = 4;
    localparam int DIGITS_DEF = 4;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_FULL    = 2'd1,
        ST_PRESENT = 2'd2
    } entry_state_t;
endpackage

// File: rtl/braille_entry_capture_if.sv
// Code hand-off bundle between the entry capture block and the downstream checker.
interface braille_entry_capture_if #(
    parameter int DIGITS = braille_pkg::DIGITS_DEF
);
    import braille_pkg::*;

    logic [CELL_W*DIGITS-1:0] code_out;
    logic                     code_valid;
    logic                     code_ready;
    logic [2:0]               digit_count;
    logic [CELL_W-1:0]        last_cell;
    logic                     entry_err;

    modport master (
        output code_out, code_valid, digit_count, last_cell, entry_err,
        input  code_ready
    );

    modport slave (
        input  code_out, code_valid, digit_count, last_cell, entry_err,
        output code_ready
    );
endinterface

// File: rtl/braille_entry_capture_btn_debounce.sv
// Button conditioner: 2-flop synchronizer, stability debouncer, press strobe.
// Latency: strobe 2+DEBOUNCE_CYCLES edges after the first sampled press.
// Backpressure: none; the strobe is a single-cycle pulse.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter bit IDLE_LVL        = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press_stb
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          sync1;
    logic          sync2;
    logic          deb;
    logic [CW-1:0] cnt;
    logic          cnt_last;

    assign cnt_last = (cnt == CW'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1     <= IDLE_LVL;
            sync2     <= IDLE_LVL;
            deb       <= IDLE_LVL;
            cnt       <= '0;
            press_stb <= 1'b0;
        end else begin
            sync1     <= btn;
            sync2     <= sync1;
            press_stb <= 1'b0;
            // The accepting sample is the DEBOUNCE_CYCLES-th consecutive mismatch.
            if (sync2 != deb) begin
                if (cnt_last) begin
                    deb       <= sync2;
                    cnt       <= '0;
                    press_stb <= (sync2 != IDLE_LVL);
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule

// File: rtl/braille_entry_capture.sv
// Braille code entry: debounced load/submit buttons assemble DIGITS cells into a code.
// Latency: cell captured 1 edge after the load strobe; code_valid 1 edge after submit.
// Backpressure: code_out/code_valid hold until an edge with code_ready high.
module braille_entry_capture
    import braille_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int DIGITS          = DIGITS_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_btn,
    input  logic [CELL_W-1:0]       cell_in,
    input  logic                    pound_n,
    braille_entry_capture_if.master cap
);
    localparam int CODE_W = CELL_W * DIGITS;

    logic load_stb;
    logic sub_stb;

    entry_state_t      state_q,  state_d;
    logic [CODE_W-1:0] code_q,   code_d;
    logic [2:0]        count_q,  count_d;
    logic [CELL_W-1:0] last_q,   last_d;
    logic              valid_q,  valid_d;
    logic              err_q,    err_d;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .IDLE_LVL(1'b0)) u_load_db (
        .clk       (clk),
        .rst       (rst),
        .btn       (load_btn),
        .press_stb (load_stb)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .IDLE_LVL(1'b1)) u_pound_db (
        .clk       (clk),
        .rst       (rst),
        .btn       (pound_n),
        .press_stb (sub_stb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_COLLECT;
            code_q  <= '0;
            count_q <= '0;
            last_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            count_q <= count_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    // Submit takes priority over a coincident load in every state.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        count_d = count_q;
        last_d  = last_q;
        valid_d = valid_q;
        err_d   = 1'b0;
        case (state_q)
            ST_COLLECT: begin
                if (sub_stb) begin
                    err_d   = 1'b1;
                    code_d  = '0;
                    count_d = '0;
                end else if (load_stb) begin
                    code_d  = (code_q << CELL_W) | CODE_W'(cell_in);
                    count_d = count_q + 3'd1;
                    last_d  = cell_in;
                    if (count_q == 3'(DIGITS - 1)) begin
                        state_d = ST_FULL;
                    end
                end
            end
            ST_FULL: begin
                if (sub_stb) begin
                    valid_d = 1'b1;
                    state_d = ST_PRESENT;
                end else if (load_stb) begin
                    err_d = 1'b1;
                end
            end
            ST_PRESENT: begin
                if (cap.code_ready) begin
                    valid_d = 1'b0;
                    code_d  = '0;
                    count_d = '0;
                    state_d = ST_COLLECT;
                end
            end
            default: state_d = ST_COLLECT;
        endcase
    end

    assign cap.code_out    = code_q;
    assign cap.code_valid  = valid_q;
    assign cap.digit_count = count_q;
    assign cap.last_cell   = last_q;
    assign cap.entry_err   = err_q;
endmodule

// File: tb/tb_braille_entry_capture.sv
// Randomized scoreboard bench for braille_entry_capture against a cell-list model.
module tb_braille_entry_capture;
    localparam int D = 4;
    localparam int N = 4;

    typedef struct {
        bit          is_code;
        logic [15:0] val;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_btn;
    logic       pound_n;
    logic [3:0] cell_in;

    int   checks   = 0;
    int   failures = 0;
    ev_t  sb[$];
    int   mcells[$];
    bit   mpresent = 1'b0;
    logic [3:0] mlast = 4'h0;

    braille_entry_capture_if #(.DIGITS(N)) cap ();

    braille_entry_capture #(.DEBOUNCE_CYCLES(D), .DIGITS(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .load_btn (load_btn),
        .cell_in  (cell_in),
        .pound_n  (pound_n),
        .cap      (cap.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_code();
        int v = 0;
        foreach (mcells[i]) v = v * 16 + mcells[i];
        return v[15:0];
    endfunction

    function automatic void push_ev(input bit is_code, input logic [15:0] val);
        ev_t e;
        e.is_code = is_code;
        e.val     = val;
        sb.push_back(e);
    endfunction

    function automatic void model_load(input logic [3:0] c);
        if (mpresent) return;
        if (mcells.size() == N) push_ev(1'b0, 16'h0);
        else begin
            mcells.push_back(int'(c));
            mlast = c;
        end
    endfunction

    function automatic void model_pound();
        if (mpresent) return;
        if (mcells.size() == N) begin
            push_ev(1'b1, model_code());
            if (cap.code_ready) mcells.delete();
            else mpresent = 1'b1;
        end else begin
            push_ev(1'b0, 16'h0);
            mcells.delete();
        end
    endfunction

    // Press for h raw cycles, then release and idle long enough to re-debounce.
    task automatic press(input bit ld, input bit pd, input logic [3:0] c, input int h);
        @(posedge clk); #1;
        cell_in  = c;
        load_btn = ld;
        pound_n  = ~pd;
        repeat (h) @(posedge clk);
        #1;
        load_btn = 1'b0;
        pound_n  = 1'b1;
        repeat (D + 8) @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [3:0] c, input int h);
        model_load(c);
        press(1'b1, 1'b0, c, h);
    endtask

    task automatic do_pound(input int h);
        model_pound();
        press(1'b0, 1'b1, 4'h0, h);
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_count"}, 32'(cap.digit_count), 32'(mcells.size()));
        chk({tag, "_code"},  32'(cap.code_out),    32'(model_code()));
        chk({tag, "_last"},  32'(cap.last_cell),   32'(mlast));
        chk({tag, "_valid"}, 32'(cap.code_valid),  32'(mpresent));
    endtask

    task automatic pulse_reset(input string tag);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        mcells.delete();
        mpresent = 1'b0;
        mlast    = 4'h0;
        sb.delete();
        check_state(tag);
        chk({tag, "_err"}, 32'(cap.entry_err), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (D + 8) @(posedge clk);
        #1;
        check_state({tag, "_release"});
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (cap.entry_err) begin
                checks++;
                if (sb.size() > 0 && !sb[0].is_code) void'(sb.pop_front());
                else begin
                    failures++;
                    $display("FAIL err_event actual=entry_err pulse required=no pulse at %0t", $time);
                end
            end
            if (cap.code_valid) begin
                if (sb.size() > 0 && sb[0].is_code) begin
                    chk("present_code", 32'(cap.code_out), 32'(sb[0].val));
                    if (cap.code_ready) void'(sb.pop_front());
                end else begin
                    checks++;
                    failures++;
                    $display("FAIL code_event actual=code_valid 0x%0h required=code_valid low at %0t",
                             cap.code_out, $time);
                end
            end
        end
    end

    initial begin
        int r;
        int k;
        logic [3:0] c;
        rst            = 1'b1;
        load_btn       = 1'b0;
        pound_n        = 1'b1;
        cell_in        = 4'h0;
        cap.code_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_state("reset");
        chk("reset_err", 32'(cap.entry_err), 32'h0);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        // Reference entry CCC3 accepted immediately.
        do_load(4'hC, 6); do_load(4'hC, 6); do_load(4'hC, 6); do_load(4'h3, 6);
        check_state("full4");
        do_pound(6);
        check_state("ccc3_done");

        // Short glitches never capture.
        model_load(4'h0);
        void'(mcells.pop_back());
        mlast = 4'h3;
        press(1'b1, 1'b0, 4'h5, D - 1);
        check_state("glitch_load");

        // Early submit is rejected and clears the partial code.
        do_load(4'h9, D); do_load(4'h6, D);
        check_state("two_cells");
        do_pound(D);
        check_state("early_pound");

        // Overflow load is rejected, code kept.
        do_load(4'h1, D); do_load(4'h2, D); do_load(4'h3, D); do_load(4'h4, D);
        do_load(4'hF, 6);
        check_state("overflow");
        do_pound(D);
        check_state("overflow_done");

        // Held presentation with code_ready low, strobes in PRESENT discarded.
        cap.code_ready = 1'b0;
        do_load(4'hA, 5); do_load(4'hB, 5); do_load(4'hC, 5); do_load(4'hD, 5);
        do_pound(5);
        k = 0;
        while (!cap.code_valid && k < 50) begin
            @(posedge clk); #1; k++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", 32'(cap.code_valid), 32'h1);
            chk("hold_code",  32'(cap.code_out),   32'hABCD);
            @(posedge clk); #1;
        end
        do_load(4'h7, 5);
        do_pound(5);
        check_state("present_ignore");
        cap.code_ready = 1'b1;
        @(posedge clk); #1;
        mcells.delete();
        mpresent = 1'b0;
        check_state("accepted");

        // Reset mid-entry, then a fresh entry.
        do_load(4'h5, D); do_load(4'h6, D);
        pulse_reset("rst_mid");
        do_load(4'h1, D); do_load(4'h2, D); do_load(4'h4, D); do_load(4'h8, D);
        check_state("after_rst");
        sb.delete();
        push_ev(1'b1, 16'h1248);
        mcells.delete();
        press(1'b0, 1'b1, 4'h0, D);
        check_state("code_1248");

        // Reset while presenting.
        cap.code_ready = 1'b0;
        do_load(4'h3, D); do_load(4'h3, D); do_load(4'h3, D); do_load(4'h3, D);
        do_pound(D);
        pulse_reset("rst_present");
        cap.code_ready = 1'b1;

        // Coincident load+submit resolves to submit.
        do_load(4'h2, D);
        model_pound();
        press(1'b1, 1'b1, 4'hE, 6);
        check_state("both_collect");

        for (int n = 0; n < 40; n++) begin
            r = int'($urandom_range(0, 99));
            c = 4'($urandom_range(0, 15));
            if (r < 55) do_load(c, int'($urandom_range(D, D + 4)));
            else if (r < 72) do_pound(int'($urandom_range(D, D + 4)));
            else if (r < 80) begin
                model_pound();
                press(1'b1, 1'b1, c, D + 1);
            end else if (r < 90) press(1'b1, 1'b0, c, int'($urandom_range(1, D - 1)));
            else press(1'b0, 1'b1, c, int'($urandom_range(1, D - 1)));
            check_state("rand");
        end

        repeat (5) @(posedge clk);
        #1;
        chk("events_drained", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/braille_entry_capture.md
BRAILLE_ENTRY_CAPTURE -- requirements
Module: braille_entry_capture

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, is the number of consecutive stable synchronized samples required to accept a button level change.
REQ-002 Parameter DIGITS, default 4, is the number of braille cells per code.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 load_btn  input  1  raw asynchronous "load cell" push button; high means pressed.
REQ-006 cell_in  input  4  raw braille cell from the input board; held stable by the user while load_btn is pressed.
REQ-007 pound_n  input  1  raw asynchronous submit (#) button; active-low, idle high.
REQ-008 code_ready  input  1  downstream checker accepts code_out.
REQ-009 code_out  output  4*DIGITS  assembled code; first-entered cell in the most-significant nibble.
REQ-010 code_valid  output  1  code_out holds a complete code awaiting acceptance.
REQ-011 digit_count  output  3  cells captured so far, 0..DIGITS.
REQ-012 last_cell  output  4  most recently captured cell, for the seven-segment display stage.
REQ-013 entry_err  output  1  one-cycle pulse on a rejected action.

Function
REQ-014 load_btn and pound_n SHALL each pass through a 2-flop synchronizer, then a debouncer.
- Debounced level changes only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles.
- Any mismatch-free break restarts the count.
REQ-015 A load strobe SHALL be a one-cycle pulse on the debounced load_btn rising edge; a submit strobe SHALL be a one-cycle pulse on the debounced pound_n falling edge.
REQ-016 cell_in SHALL be sampled in the load-strobe cycle; digit_count, code_out and last_cell SHALL update on the following edge (2+DEBOUNCE_CYCLES+1 edges after the first sampled press).
REQ-017 The state machine SHALL have three states:
- COLLECT: digit_count < DIGITS.
- FULL: digit_count == DIGITS.
- PRESENT: code_valid high.
REQ-018 In COLLECT, a load strobe SHALL shift code_out left by 4, insert cell_in at bits [3:0], and increment digit_count; at DIGITS it SHALL go to FULL.
REQ-019 In FULL, a load strobe SHALL be ignored except for a one-cycle entry_err pulse; code_out and digit_count SHALL be unchanged.
REQ-020 In FULL, a submit strobe SHALL assert code_valid on the next edge and enter PRESENT.
REQ-021 In COLLECT, a submit strobe SHALL pulse entry_err and clear digit_count and code_out to 0.
REQ-022 In PRESENT:
- code_out and code_valid SHALL stay stable until a rising edge with code_ready high.
- That edge SHALL clear code_valid, digit_count and code_out and return to COLLECT.
- Load and submit strobes in PRESENT SHALL be discarded without entry_err.
REQ-023 A load strobe and a submit strobe in the same cycle SHALL be resolved as submit only; the load SHALL be dropped.
REQ-024 digit_count SHALL never exceed DIGITS or wrap.

Reset
REQ-025 Asserting rst SHALL immediately force:
- code_out = 0, code_valid = 0, digit_count = 0, last_cell = 0, entry_err = 0.
- State = COLLECT, debounce counters = 0.
- Debounced load level = 0, debounced pound_n level = 1, synchronizer flops to these idle levels.
REQ-026 Reset mid-entry or during PRESENT SHALL discard the partial or pending code; no strobe SHALL be generated on reset release while buttons are at idle level.

Structure
REQ-027 A shared package braille_pkg SHALL hold CELL_W = 4, the default DIGITS, and the state enumeration type.
REQ-028 A sub-module btn_debounce (synchronizer + debouncer + edge strobe, parameterized by DEBOUNCE_CYCLES and idle level) SHALL be instantiated twice.

Verification
REQ-029 Cells 1100, 1100, 1100, 0011 each held 6 cycles, then pound_n low 6 cycles, with code_ready high -> code_out = 0xCCC3, code_valid high for exactly 1 cycle, digit_count then 0.
REQ-030 load_btn high for DEBOUNCE_CYCLES-1 synchronized cycles only -> no capture, digit_count stays 0.
REQ-031 Two cells entered, then pound -> entry_err 1-cycle pulse, digit_count = 0, code_out = 0, code_valid never high.
REQ-032 Four cells entered, then a fifth load of 1111 -> entry_err pulse, code_out unchanged, digit_count = 4.
REQ-033 Complete code submitted with code_ready low for 5 cycles -> code_valid and code_out held constant for 5 cycles, cleared on the edge code_ready rises.
REQ-034 rst pulsed after two cells -> all outputs 0 immediately; next four-cell entry of 0001, 0010, 0100, 1000 + pound -> code_out = 0x1248.
